// File: rtl/ddr_tx_pkg.sv
// Shared definitions for the HDR-DDR transmit framer.
//   state_e        : framer FSM states
//   PRE_*/CRC_*    : word preambles, CRC token and CRC seed
//   ddr_parity     : 2-bit DDR word parity {PA1, PA0}
//   ddr_crc5_word  : CRC-5 (x^5+x^2+1) advanced over one 16-bit word, MSB first
package ddr_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_CRC,
    ST_DONE
  } state_e;

  localparam logic [1:0]  PRE_CMD   = 2'b01;
  localparam logic [1:0]  PRE_DATA  = 2'b10;
  localparam logic [3:0]  CRC_TOKEN = 4'hC;
  localparam logic [4:0]  CRC_INIT  = 5'h1F;
  localparam logic [4:0]  CRC_POLY  = 5'b00101;
  localparam int unsigned WORD_BITS = 20;
  localparam int unsigned CRC_BITS  = 11;

  function automatic logic [1:0] ddr_parity(input logic [15:0] d);
    logic pa1;
    logic pa0;
    pa1 = 1'b0;
    pa0 = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      pa1 ^= d[2*i+1];
      pa0 ^= d[2*i];
    end
    return {pa1, pa0};
  endfunction

  function automatic logic [4:0] ddr_crc5_word(input logic [4:0] crc, input logic [15:0] d);
    logic [4:0] c;
    logic       fb;
    c = crc;
    for (int unsigned i = 16; i > 0; i--) begin
      fb = c[4] ^ d[i-1];
      c  = {c[3:0], 1'b0};
      if (fb) c ^= CRC_POLY;
    end
    return c;
  endfunction

  function automatic logic [19:0] ddr_frame_word(input logic [1:0] pre, input logic [15:0] d);
    return {pre, d, ddr_parity(d)};
  endfunction

endpackage

// File: rtl/ddr_tx_shifter.sv
// 20-bit load/shift register with bit counter; bit 19 drives SDA directly.
//   clk_i, rst_ni : clock, async active-low reset
//   clr_i         : fill with IDLE_LEVEL and zero the counter
//   load_i/word_i : load a new word (MSB first), counter to 0
//   shift_i       : advance one bit, counter +1
//   bit_o         : current serial bit (registered)
//   cnt_o         : index of the bit currently on bit_o
module ddr_tx_shifter #(
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        load_i,
  input  logic [19:0] word_i,
  input  logic        shift_i,
  output logic        bit_o,
  output logic [4:0]  cnt_o
);

  logic [19:0] sr_q;
  logic [4:0]  cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q  <= {20{IDLE_LEVEL}};
      cnt_q <= '0;
    end else if (clr_i) begin
      sr_q  <= {20{IDLE_LEVEL}};
      cnt_q <= '0;
    end else if (load_i) begin
      sr_q  <= word_i;
      cnt_q <= '0;
    end else if (shift_i) begin
      sr_q  <= {sr_q[18:0], IDLE_LEVEL};
      cnt_q <= cnt_q + 5'd1;
    end
  end

  assign bit_o = sr_q[19];
  assign cnt_o = cnt_q;

endmodule

// File: rtl/ddr_tx_framer.sv
// HDR-DDR transmit framer: command word, up to MAX_WORDS data words pulled
// from the register file, then an optional CRC word, one bit per SCL strobe.
//   i_sys_clk, i_sys_rst_n         : clock, async active-low reset
//   i_sclgen_scl_pos/neg_edge      : bit-slot strobes (OR-ed into one slot)
//   i_ddrccc_tx_en/cmd/word_count  : frame start request (IDLE only)
//   i_regf_data/_valid, o_regf_rd_en : data word source and pop
//   o_sdahnd_serial_data           : serial SDA
//   o_ddrccc_busy/mode_done/underrun : status
module ddr_tx_framer
  import ddr_tx_pkg::*;
#(
  parameter int unsigned MAX_WORDS  = 32,
  parameter int unsigned CNT_W      = $clog2(MAX_WORDS + 1),
  parameter bit          CRC_EN     = 1'b1,
  parameter logic        IDLE_LEVEL = 1'b1
) (
  input  logic             i_sys_clk,
  input  logic             i_sys_rst_n,
  input  logic             i_sclgen_scl_pos_edge,
  input  logic             i_sclgen_scl_neg_edge,
  input  logic             i_ddrccc_tx_en,
  input  logic [15:0]      i_ddrccc_cmd_word,
  input  logic [CNT_W-1:0] i_ddrccc_word_count,
  input  logic [15:0]      i_regf_data,
  input  logic             i_regf_data_valid,
  output logic             o_regf_rd_en,
  output logic             o_sdahnd_serial_data,
  output logic             o_ddrccc_busy,
  output logic             o_ddrccc_mode_done,
  output logic             o_ddrccc_underrun
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] left_q, left_d;
  logic             has_data_q, has_data_d;
  logic [4:0]       crc_q, crc_d;
  logic             busy_q, busy_d;
  logic             rd_en_q, rd_en_d;
  logic             done_q, done_d;
  logic             unr_q, unr_d;

  logic             sh_clr, sh_load, sh_shift;
  logic [19:0]      sh_word;
  logic [4:0]       sh_cnt;
  logic             slot, last_bit;
  logic [CNT_W-1:0] cnt_clamped;

  assign slot        = i_sclgen_scl_pos_edge | i_sclgen_scl_neg_edge;
  assign last_bit    = (state_q == ST_CRC) ? (sh_cnt == 5'(CRC_BITS - 1))
                                           : (sh_cnt == 5'(WORD_BITS - 1));
  assign cnt_clamped = (i_ddrccc_word_count > CNT_W'(MAX_WORDS)) ? CNT_W'(MAX_WORDS)
                                                                 : i_ddrccc_word_count;

  always_comb begin
    state_d    = state_q;
    left_d     = left_q;
    has_data_d = has_data_q;
    crc_d      = crc_q;
    busy_d     = busy_q;
    rd_en_d    = 1'b0;
    done_d     = 1'b0;
    unr_d      = 1'b0;
    sh_clr     = 1'b0;
    sh_load    = 1'b0;
    sh_shift   = 1'b0;
    sh_word    = '0;

    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (i_ddrccc_tx_en) begin
          state_d    = ST_CMD;
          left_d     = cnt_clamped;
          has_data_d = (cnt_clamped != '0);
          crc_d      = CRC_INIT;
          busy_d     = 1'b1;
          sh_load    = 1'b1;
          sh_word    = ddr_frame_word(PRE_CMD, i_ddrccc_cmd_word);
        end
      end

      ST_CMD, ST_DATA, ST_CRC: begin
        if (slot) begin
          if (!last_bit) begin
            sh_shift = 1'b1;
          end else if (state_q != ST_CRC && left_q != '0) begin
            // Next data word is fetched on the final strobe of the current
            // word so it starts on the very next slot without a gap.
            if (i_regf_data_valid) begin
              state_d = ST_DATA;
              left_d  = left_q - CNT_W'(1);
              crc_d   = ddr_crc5_word(crc_q, i_regf_data);
              rd_en_d = 1'b1;
              sh_load = 1'b1;
              sh_word = ddr_frame_word(PRE_DATA, i_regf_data);
            end else begin
              state_d = ST_IDLE;
              crc_d   = CRC_INIT;
              busy_d  = 1'b0;
              unr_d   = 1'b1;
              sh_clr  = 1'b1;
            end
          end else if (state_q != ST_CRC && CRC_EN && has_data_q) begin
            state_d = ST_CRC;
            sh_load = 1'b1;
            sh_word = {PRE_CMD, CRC_TOKEN, crc_q, 9'd0};
          end else begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            sh_clr  = 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        crc_d   = CRC_INIT;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        sh_clr  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_q    <= ST_IDLE;
      left_q     <= '0;
      has_data_q <= 1'b0;
      crc_q      <= CRC_INIT;
      busy_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      done_q     <= 1'b0;
      unr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      left_q     <= left_d;
      has_data_q <= has_data_d;
      crc_q      <= crc_d;
      busy_q     <= busy_d;
      rd_en_q    <= rd_en_d;
      done_q     <= done_d;
      unr_q      <= unr_d;
    end
  end

  ddr_tx_shifter #(
    .IDLE_LEVEL(IDLE_LEVEL)
  ) u_shifter (
    .clk_i  (i_sys_clk),
    .rst_ni (i_sys_rst_n),
    .clr_i  (sh_clr),
    .load_i (sh_load),
    .word_i (sh_word),
    .shift_i(sh_shift),
    .bit_o  (o_sdahnd_serial_data),
    .cnt_o  (sh_cnt)
  );

  assign o_regf_rd_en       = rd_en_q;
  assign o_ddrccc_busy      = busy_q;
  assign o_ddrccc_mode_done = done_q;
  assign o_ddrccc_underrun  = unr_q;

endmodule

// File: tb/tb_ddr_tx_framer.sv
// Randomized scoreboard bench for ddr_tx_framer.
module tb_ddr_tx_framer;

  localparam int unsigned MW   = 5;
  localparam int unsigned CW   = $clog2(MW + 1);
  localparam bit          CRCE = 1'b1;
  localparam logic        IDL  = 1'b1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          pos, neg, tx_en, rvalid;
  logic [15:0]   cmd, rdata;
  logic [CW-1:0] cnt;
  logic          rd_en, sda, busy, done, unr;

  ddr_tx_framer #(
    .MAX_WORDS (MW),
    .CNT_W     (CW),
    .CRC_EN    (CRCE),
    .IDLE_LEVEL(IDL)
  ) dut (
    .i_sys_clk            (clk),
    .i_sys_rst_n          (rst_n),
    .i_sclgen_scl_pos_edge(pos),
    .i_sclgen_scl_neg_edge(neg),
    .i_ddrccc_tx_en       (tx_en),
    .i_ddrccc_cmd_word    (cmd),
    .i_ddrccc_word_count  (cnt),
    .i_regf_data          (rdata),
    .i_regf_data_valid    (rvalid),
    .o_regf_rd_en         (rd_en),
    .o_sdahnd_serial_data (sda),
    .o_ddrccc_busy        (busy),
    .o_ddrccc_mode_done   (done),
    .o_ddrccc_underrun    (unr)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  bit          exp_bits[$];
  int          exp_evt[$];   // 1 = done, 2 = underrun
  int          exp_rd[$];
  logic [15:0] stim_words[$];
  logic [15:0] src_q[$];
  int          rd_seen = 0;
  int          bit_idx = 0;

  // ---------------- reference model ----------------
  function automatic logic [1:0] m_parity(input logic [15:0] d);
    int odd, even;
    logic [1:0] p;
    odd = 0;
    even = 0;
    for (int i = 0; i < 16; i++)
      if (d[i]) begin
        if (i % 2 == 1) odd++;
        else            even++;
      end
    p[1] = (odd % 2) == 1;
    p[0] = (even % 2) == 0;
    return p;
  endfunction

  // Remainder of (crc*x^16 + d*x^5) mod (x^5+x^2+1) by long division.
  function automatic logic [4:0] m_crc(input logic [4:0] crc, input logic [15:0] d);
    logic [20:0] v;
    v = {crc, 16'h0000} ^ {d, 5'b00000};
    for (int i = 20; i >= 5; i--)
      if (v[i]) v = v ^ (21'h25 << (i - 5));
    return v[4:0];
  endfunction

  task automatic push_bits(input logic [19:0] w, input int n);
    for (int i = 0; i < n; i++) exp_bits.push_back(w[19-i]);
  endtask

  task automatic model(input logic [15:0] c, input logic [CW-1:0] n);
    int nw, rd;
    bit ok;
    logic [4:0] crc;
    nw  = (int'(n) > int'(MW)) ? int'(MW) : int'(n);
    push_bits({2'b01, c, m_parity(c)}, 20);
    crc = 5'h1F;
    rd  = 0;
    ok  = 1'b1;
    for (int k = 0; k < nw; k++) begin
      if (k >= stim_words.size()) begin
        ok = 1'b0;
        break;
      end
      push_bits({2'b10, stim_words[k], m_parity(stim_words[k])}, 20);
      crc = m_crc(crc, stim_words[k]);
      rd++;
    end
    if (ok && CRCE && nw > 0) push_bits({2'b01, 4'hC, crc, 9'h000}, 11);
    exp_evt.push_back(ok ? 1 : 2);
    exp_rd.push_back(rd);
  endtask

  // ---------------- stimulus ----------------
  task automatic drive_regf();
    rvalid = (src_q.size() > 0);
    rdata  = (src_q.size() > 0) ? src_q[0] : 16'hDEAD;
  endtask

  task automatic tick(input bit noise);
    int r;
    @(posedge clk);
    #1;
    if (rd_en && src_q.size() > 0) void'(src_q.pop_front());
    drive_regf();
    r   = $urandom_range(0, 5);
    pos = (r == 1 || r == 2 || r == 5);
    neg = (r == 3 || r == 4 || r == 5);
    tx_en = noise && busy && ($urandom_range(0, 7) == 0);
    if (tx_en) begin
      cmd = 16'($urandom);
      cnt = CW'($urandom_range(0, (1 << CW) - 1));
    end
  endtask

  task automatic start_frame(input logic [15:0] c, input logic [CW-1:0] n);
    src_q = stim_words;
    model(c, n);
    bit_idx = 0;
    cmd     = c;
    cnt     = n;
    tx_en   = 1'b1;
    drive_regf();
  endtask

  task automatic wait_frame(input bit noise);
    int budget;
    budget = 8 * (20 * (int'(MW) + 1) + 11) + 20;
    for (int c = 0; c < budget && exp_evt.size() > 0; c++) tick(noise);
    if (exp_evt.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout got=no_end exp=done_or_underrun");
      exp_bits.delete();
      exp_evt.delete();
      exp_rd.delete();
    end
    tick(1'b0);
  endtask

  task automatic run_frame(input logic [15:0] c, input logic [CW-1:0] n, input bit noise);
    start_frame(c, n);
    wait_frame(noise);
  endtask

  task automatic check_reset_state(input string tag);
    checks++;
    if (sda !== IDL || busy !== 1'b0 || rd_en !== 1'b0 || done !== 1'b0 || unr !== 1'b0) begin
      errors++;
      $display("FAIL %s got sda=%b busy=%b rd=%b done=%b unr=%b exp sda=%b others=0",
               tag, sda, busy, rd_en, done, unr, IDL);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_en) rd_seen++;
      if (busy && (pos || neg)) begin
        checks++;
        if (exp_bits.size() == 0) begin
          errors++;
          $display("FAIL extra_bit idx=%0d got=%b exp=none", bit_idx, sda);
        end else begin
          bit b;
          b = exp_bits.pop_front();
          if (sda !== b) begin
            errors++;
            $display("FAIL sda_bit idx=%0d got=%b exp=%b", bit_idx, sda, b);
          end
        end
        bit_idx++;
      end
      if (done || unr) begin
        int ev;
        ev = (done && unr) ? 3 : (done ? 1 : 2);
        checks++;
        if (exp_evt.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event got=%0d exp=none", ev);
        end else begin
          int e, r;
          e = exp_evt.pop_front();
          r = exp_rd.pop_front();
          if (ev != e) begin
            errors++;
            $display("FAIL end_event got=%0d exp=%0d", ev, e);
          end
          checks++;
          if (rd_seen != r) begin
            errors++;
            $display("FAIL rd_en_count got=%0d exp=%0d", rd_seen, r);
          end
          checks++;
          if (exp_bits.size() != 0) begin
            errors++;
            $display("FAIL frame_length got=%0d exp=%0d", bit_idx, bit_idx + exp_bits.size());
          end
          checks++;
          if (sda !== IDL || busy !== 1'b0) begin
            errors++;
            $display("FAIL end_idle got sda=%b busy=%b exp sda=%b busy=0", sda, busy, IDL);
          end
        end
        exp_bits.delete();
        rd_seen = 0;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [CW-1:0] n;
    int nw, navail;
    pos = 1'b0; neg = 1'b0; tx_en = 1'b0; cmd = '0; cnt = '0;
    rdata = '0; rvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_state("reset_values");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick(1'b0);
    check_reset_state("post_reset_idle");

    // Command only
    stim_words = {};
    run_frame(16'h8012, CW'(0), 1'b0);
    // One data word with CRC
    stim_words = {16'hFFFF};
    run_frame(16'h0000, CW'(1), 1'b0);
    // Three data words, tx_en noise and simultaneous strobes
    stim_words = {16'h0001, 16'h0000, 16'hAAAA};
    run_frame(16'h1234, CW'(3), 1'b1);
    // Underrun before word 2
    stim_words = {16'h5A5A};
    run_frame(16'hC3C3, CW'(2), 1'b0);
    // Count above MAX_WORDS is clamped
    stim_words = {16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777};
    run_frame(16'hBEEF, CW'(7), 1'b1);

    // Randomized frames
    for (int t = 0; t < 12; t++) begin
      n  = CW'($urandom_range(0, (1 << CW) - 1));
      nw = (int'(n) > int'(MW)) ? int'(MW) : int'(n);
      navail = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nw) : nw;
      stim_words = {};
      for (int k = 0; k < navail; k++) stim_words.push_back(16'($urandom));
      run_frame(16'($urandom), n, 1'b1);
    end

    // Reset mid-frame at slot 7 of a count=2 frame
    stim_words = {16'h0F0F, 16'hF0F0};
    start_frame(16'h4321, CW'(2));
    for (int c = 0; c < 200 && bit_idx < 7; c++) tick(1'b0);
    rst_n = 1'b0;
    #1 check_reset_state("midframe_reset");
    exp_bits.delete();
    exp_evt.delete();
    exp_rd.delete();
    src_q.delete();
    rd_seen = 0;
    tx_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick(1'b0);
      check_reset_state("after_reset_quiet");
    end

    // Fresh frame after the reset
    stim_words = {16'h0F0F, 16'hF0F0};
    run_frame(16'h4321, CW'(2), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
